a429_tx_sched: RTL

Periodic label scheduler and write-port arbiter for the ARINC429 TX FIFO. It holds a table of NSLOT transmit words, each with a millisecond period. It queues expired slots and pushes them into the TX FIFO write port, which it shares round-robin among slots and with priority for an aperiodic host write path. It sits between the command/status block and the TX FIFO, replacing the direct host-to-FIFO write connection.

---
 rtl/a429_sched_pkg.sv | 22 ++
 rtl/a429_rr_arb.sv | 33 +++
 rtl/a429_tx_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/a429_sched_pkg.sv
// Shared field codes, FSM encoding and width helper for the ARINC429 TX scheduler.
// Used by a429_tx_sched and a429_rr_arb.
package a429_sched_pkg;

  localparam logic [1:0] FLD_WORD = 2'd0;
  localparam logic [1:0] FLD_PER  = 2'd1;
  localparam logic [1:0] FLD_CTRL = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_e;

  // Bit width needed to index n items; never less than 1 so one-slot vectors stay legal.
  function automatic int a429_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/a429_rr_arb.sv
// Combinational round-robin arbiter: grants the first request found after the pointer,
// wrapping to 0. The pointer register lives in the parent.
module a429_rr_arb
  import a429_sched_pkg::*;
#(
  parameter int NSLOT = 8,
  parameter int SEL_W = a429_clog2(NSLOT)
) (
  input  logic [NSLOT-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [NSLOT-1:0] gnt_o,
  output logic             valid_o
);

  function automatic logic [SEL_W-1:0] wrapIdx(input logic [SEL_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NSLOT) s = s - NSLOT;
    return s[SEL_W-1:0];
  endfunction

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= NSLOT; k++) begin
      if (!valid_o && req_i[wrapIdx(ptr_i, k)]) begin
        gnt_o[wrapIdx(ptr_i, k)] = 1'b1;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/a429_tx_sched.sv
// Periodic label scheduler and TX FIFO write-port arbiter (host path has priority).
// Optional sticky overrun flags and the ovr_o port exist only with A429_SCHED_OVR_EN.
module a429_tx_sched
  import a429_sched_pkg::*;
#(
  parameter int CLOCK_KHZ = 100000,
  parameter int NSLOT     = 8,
  parameter int PER_W     = 16,
  localparam int SEL_W    = a429_clog2(NSLOT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sch_ena,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [1:0]       cfg_fld,
  input  logic [31:0]      cfg_dat,
  input  logic             hw_req,
  input  logic [31:0]      hw_dat,
  output logic             hw_ack,
  output logic             tf_wr,
  output logic [31:0]      tf_di,
  input  logic             tf_fl,
  output logic             tick_o,
  output logic [NSLOT-1:0] pend_o
`ifdef A429_SCHED_OVR_EN
  ,output logic [NSLOT-1:0] ovr_o
`endif
);

  localparam int PRE_W = a429_clog2(CLOCK_KHZ);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick;
  logic [31:0]      word_q [NSLOT];
  logic [31:0]      word_d [NSLOT];
  logic [PER_W-1:0] per_q  [NSLOT];
  logic [PER_W-1:0] per_d  [NSLOT];
  logic [PER_W-1:0] cnt_q  [NSLOT];
  logic [PER_W-1:0] cnt_d  [NSLOT];
  logic [NSLOT-1:0] en_q, en_d, pend_q, pend_d, expire, take, gnt;
  logic             arbValid, grantSlot;
  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, gntIdx;
  logic             host_q, host_d;
  logic [31:0]      dat_q, dat_d;
`ifdef A429_SCHED_OVR_EN
  logic [NSLOT-1:0] ovr_q, ovr_d;
`endif

  assign tick    = (presc_q == PRE_W'(CLOCK_KHZ - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  a429_rr_arb #(.NSLOT(NSLOT), .SEL_W(SEL_W)) u_arb (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (arbValid)
  );

  always_comb begin
    gntIdx = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (gnt[i]) gntIdx = SEL_W'(i);
    end
  end

  // A period of zero keeps cnt at 0 without ever raising an expiry.
  always_comb begin
    expire = '0;
    for (int i = 0; i < NSLOT; i++) begin
      expire[i] = tick && sch_ena && en_q[i] && (cnt_q[i] == '0) && (per_q[i] != '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    host_d    = host_q;
    dat_d     = dat_q;
    grantSlot = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tf_fl) begin
          if (hw_req) begin
            dat_d   = hw_dat;
            host_d  = 1'b1;
            state_d = WR;
          end else if (sch_ena && arbValid) begin
            dat_d     = word_q[gntIdx];
            host_d    = 1'b0;
            ptr_d     = gntIdx;
            grantSlot = 1'b1;
            state_d   = WR;
          end
        end
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    take = grantSlot ? gnt : '0;
  end

  // Config writes take precedence over countdown; a fresh expiry re-arms pend even when granted.
  always_comb begin
    word_d = word_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    pend_d = pend_q;
`ifdef A429_SCHED_OVR_EN
    ovr_d  = ovr_q;
`endif
    for (int i = 0; i < NSLOT; i++) begin
      if (tick && sch_ena && en_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
      if (expire[i]) cnt_d[i] = per_q[i] - 1'b1;
      pend_d[i] = sch_ena && ((pend_q[i] && !take[i]) || expire[i]);
`ifdef A429_SCHED_OVR_EN
      if (expire[i] && pend_q[i] && !take[i]) ovr_d[i] = 1'b1;
`endif
      if (cfg_we && (cfg_sel == SEL_W'(i))) begin
        case (cfg_fld)
          FLD_WORD: word_d[i] = cfg_dat;
          FLD_PER:  per_d[i]  = cfg_dat[PER_W-1:0];
          FLD_CTRL: begin
            en_d[i]   = cfg_dat[0];
            cnt_d[i]  = '0;
            pend_d[i] = 1'b0;
`ifdef A429_SCHED_OVR_EN
            ovr_d[i]  = 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      ptr_q   <= SEL_W'(NSLOT - 1);
      host_q  <= 1'b0;
      dat_q   <= '0;
`ifdef A429_SCHED_OVR_EN
      ovr_q   <= '0;
`endif
      for (int i = 0; i < NSLOT; i++) begin
        word_q[i] <= '0;
        per_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      host_q  <= host_d;
      dat_q   <= dat_d;
`ifdef A429_SCHED_OVR_EN
      ovr_q   <= ovr_d;
`endif
      for (int i = 0; i < NSLOT; i++) begin
        word_q[i] <= word_d[i];
        per_q[i]  <= per_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Reset during the WR cycle drops the in-flight write.
  assign tf_wr  = (state_q == WR) && !rst_i;
  assign hw_ack = tf_wr && host_q;
  assign tf_di  = dat_q;
  assign tick_o = tick;
  assign pend_o = pend_q;
`ifdef A429_SCHED_OVR_EN
  assign ovr_o  = ovr_q;
`endif

endmodule
